// File: rtl/alu_pkg.sv
// Shared ALU constants and the packed result record carried through the
// result queue (data word, signed-overflow flag, destination tag).
package alu_pkg;

  localparam int ALU_DATA_W = 64;
  localparam int ALU_TAG_W  = 5;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic                  ovf;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_result_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Valid/ready bus between the ALU (producer), the result queue and writeback
// (consumer). The slave modport is the queue's view; master is the view of
// the block driving ALU results in and consuming queue heads.
interface alu_result_queue_if #(
  parameter int DATA_W = alu_pkg::ALU_DATA_W,
  parameter int TAG_W  = alu_pkg::ALU_TAG_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ovf;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_data, in_ovf, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_tag
  );

  modport master (
    output in_valid, in_data, in_ovf, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_tag
  );

endinterface

// File: rtl/alu_rq_storage.sv
// Entry storage for the ALU result queue: DEPTH registers of alu_result_t,
// one synchronous write port and one asynchronous (combinational) read port.
// Contents are cleared on reset so the head reads zero after reset.
module alu_rq_storage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  alu_result_t              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output alu_result_t              rd_data
);

  alu_result_t mem [DEPTH];

  // Write one entry per cycle; whole array cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_queue.sv
// ALU result queue: valid/ready FIFO between the add/subtract unit and
// writeback, plus overflow statistics (sticky flag, saturating counter).
// Optional feature macro: ALU_RESULT_QUEUE_OVF_TRAP_EN -- when defined, an
// accepted overflowed result raises a one-cycle ovf_trap pulse with its tag
// and is dropped instead of being queued.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = ALU_TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_queue_if.slave      bus,
  input  logic                   clr_sticky,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_sticky,
  output logic [15:0]            ovf_count,
  output logic                   ovf_trap,
  output logic [TAG_W-1:0]       trap_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [15:0]   OVF_CNT_MAX = 16'hFFFF;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          store;
  logic          ovf_push;
  alu_result_t   wr_entry;
  alu_result_t   head;

  // Ready/valid come only from the registered count, so there is no
  // combinational path from out_ready to in_ready.
  assign bus.in_ready  = (count != CNT_FULL);
  assign bus.out_valid = (count != '0);

  assign push     = bus.in_valid & bus.in_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign ovf_push = push & bus.in_ovf;

`ifdef ALU_RESULT_QUEUE_OVF_TRAP_EN
  // Overflowed results are diverted to the trap path instead of the FIFO.
  assign store = push & ~bus.in_ovf;
`else
  assign store = push;
`endif

  assign wr_entry = '{data: bus.in_data, ovf: bus.in_ovf, tag: bus.in_tag};

  alu_rq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign bus.out_data = head.data;
  assign bus.out_ovf  = head.ovf;
  assign bus.out_tag  = head.tag;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({store, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Overflow statistics: sticky flag (set beats clear) and saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      if (ovf_push)        ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
      if (ovf_push && ovf_count != OVF_CNT_MAX) ovf_count <= ovf_count + 16'd1;
    end
  end

`ifdef ALU_RESULT_QUEUE_OVF_TRAP_EN
  // One-cycle trap pulse after an accepted overflowed result, with its tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_trap <= 1'b0;
      trap_tag <= '0;
    end else begin
      ovf_trap <= ovf_push;
      if (ovf_push) trap_tag <= bus.in_tag;
    end
  end
`else
  assign ovf_trap = 1'b0;
  assign trap_tag = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed testbench for alu_result_queue (DEPTH=4). Expectations are
// hand-computed; the trap build variant is covered by ALU_RESULT_QUEUE_OVF_TRAP_EN.
module tb_alu_result_queue;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        clr_sticky;
  logic [2:0]  count;
  logic        ovf_sticky;
  logic [15:0] ovf_count;
  logic        ovf_trap;
  logic [4:0]  trap_tag;

  int checks = 0;
  int errors = 0;

  alu_result_queue_if bus_if ();

  alu_result_queue #(
    .DATA_W (64),
    .TAG_W  (5),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .clr_sticky (clr_sticky),
    .count      (count),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .ovf_trap   (ovf_trap),
    .trap_tag   (trap_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic o, input logic [4:0] t);
    bus_if.in_valid = v;
    bus_if.in_data  = d;
    bus_if.in_ovf   = o;
    bus_if.in_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_sticky = 1'b0;
    bus_if.out_ready = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus_if.out_valid); end
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus_if.in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (bus_if.out_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", bus_if.out_data); end
    checks++; if (ovf_sticky !== 1'b0 || ovf_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_stats got %b/%h want 0/0", ovf_sticky, ovf_count); end
    checks++; if (ovf_trap !== 1'b0 || trap_tag !== 5'd0) begin errors++; $display("[TB] FAIL reset_trap got %b/%0d want 0/0", ovf_trap, trap_tag); end
  endtask

  // -2^63 - (2^63-1) wraps to 1 with signed overflow.
  task automatic test_ovf_push();
    drive(1'b1, 64'h1, 1'b1, 5'd3);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_set got %b want 1", ovf_sticky); end
    checks++; if (ovf_count !== 16'd1) begin errors++; $display("[TB] FAIL ovf_count_1 got %0d want 1", ovf_count); end
`ifdef ALU_RESULT_QUEUE_OVF_TRAP_EN
    checks++; if (ovf_trap !== 1'b1 || trap_tag !== 5'd3) begin errors++; $display("[TB] FAIL trap_pulse got %b/%0d want 1/3", ovf_trap, trap_tag); end
    checks++; if (count !== 3'd0 || bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_not_stored got count %0d valid %b want 0/0", count, bus_if.out_valid); end
    tick();
    checks++; if (ovf_trap !== 1'b0) begin errors++; $display("[TB] FAIL trap_one_cycle got %b want 0", ovf_trap); end
`else
    checks++; if (bus_if.out_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("[TB] FAIL ovf_entry_valid got valid %b count %0d want 1/1", bus_if.out_valid, count); end
    checks++; if (bus_if.out_data !== 64'h1 || bus_if.out_ovf !== 1'b1 || bus_if.out_tag !== 5'd3) begin
      errors++; $display("[TB] FAIL ovf_entry_head got %h/%b/%0d want 1/1/3", bus_if.out_data, bus_if.out_ovf, bus_if.out_tag);
    end
    checks++; if (ovf_trap !== 1'b0) begin errors++; $display("[TB] FAIL trap_disabled got %b want 0", ovf_trap); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL ovf_drain got %0d want 0", count); end
`endif
  endtask

  logic [63:0] fill_data [4] = '{64'h0000_1DA3_8D1E_5F6C, 64'hFFFF_FFFF_FFFF_FFFE,
                                  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
  logic [4:0]  fill_tag  [4] = '{5'd10, 5'd11, 5'd12, 5'd31};

  task automatic test_fill_full();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_data[i], 1'b0, fill_tag[i]);
      tick();
    end
    checks++; if (count !== 3'd4 || bus_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_state got count %0d ready %b want 4/0", count, bus_if.in_ready); end
    drive(1'b1, 64'hDEAD_BEEF, 1'b1, 5'd9);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_ignore_count got %0d want 4", count); end
    checks++; if (ovf_count !== 16'd1) begin errors++; $display("[TB] FAIL full_ignore_stats got %0d want 1", ovf_count); end
    checks++; if (bus_if.out_data !== fill_data[0] || bus_if.out_tag !== fill_tag[0]) begin
      errors++; $display("[TB] FAIL full_head got %h/%0d want %h/%0d", bus_if.out_data, bus_if.out_tag, fill_data[0], fill_tag[0]);
    end
  endtask

  task automatic test_full_pop();
    drive(1'b1, 64'h5555, 1'b0, 5'd1);
    bus_if.out_ready = 1'b1;
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    bus_if.out_ready = 1'b0;
    checks++; if (count !== 3'd3 || bus_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_only got count %0d ready %b want 3/1", count, bus_if.in_ready); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (bus_if.out_data !== fill_data[i] || bus_if.out_tag !== fill_tag[i] || bus_if.out_ovf !== 1'b0) begin
        errors++; $display("[TB] FAIL pop_order_%0d got %h/%0d want %h/%0d", i, bus_if.out_data, bus_if.out_tag, fill_data[i], fill_tag[i]);
      end
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
    end
    checks++; if (count !== 3'd0 || bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got count %0d valid %b want 0/0", count, bus_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h100 + 64'(i), 1'b0, 5'(i));
      q.push_back(64'h100 + 64'(i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h200 + 64'(i), 1'b0, 5'(i));
      bus_if.out_ready = 1'b1;
      checks++; if (bus_if.out_data !== q[0]) begin errors++; $display("[TB] FAIL b2b_order_%0d got %h want %h", i, bus_if.out_data, q[0]); end
      tick();
      void'(q.pop_front());
      q.push_back(64'h200 + 64'(i));
      checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count_%0d got %0d want 2", i, count); end
    end
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus_if.out_data !== q[0]) begin errors++; $display("[TB] FAIL b2b_drain_%0d got %h want %h", i, bus_if.out_data, q[0]); end
      tick();
      void'(q.pop_front());
    end
    bus_if.out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_empty got %0d want 0", count); end
  endtask

  task automatic test_sticky();
    bus_if.out_ready = 1'b1;
    clr_sticky = 1'b1;
    drive(1'b1, 64'h77, 1'b1, 5'd4);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("[TB] FAIL sticky_set_wins got %b want 1", ovf_sticky); end
    checks++; if (ovf_count !== 16'd2) begin errors++; $display("[TB] FAIL sticky_count got %0d want 2", ovf_count); end
    tick();
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL sticky_clear got %b want 0", ovf_sticky); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL sticky_drained got %0d want 0", count); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_ovf_saturate();
    bus_if.out_ready = 1'b1;
    drive(1'b1, 64'h1, 1'b1, 5'd2);
    repeat (65532) tick();
    checks++; if (ovf_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_near got %h want fffe", ovf_count); end
    repeat (8) tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold got %h want ffff", ovf_count); end
    tick();
    bus_if.out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL sat_drained got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hA0 + 64'(i), 1'b0, 5'(i));
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_count got %0d want 3", count); end
    drive(1'b1, 64'hBB, 1'b1, 5'd5);
    bus_if.out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_if.out_valid !== 1'b0 || count !== 3'd0 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL async_reset got valid %b count %0d ready %b want 0/0/1", bus_if.out_valid, count, bus_if.in_ready);
    end
    checks++; if (ovf_count !== 16'h0 || ovf_sticky !== 1'b0 || bus_if.out_data !== 64'h0) begin
      errors++; $display("[TB] FAIL async_reset_state got %h/%b/%h want 0/0/0", ovf_count, ovf_sticky, bus_if.out_data);
    end
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    bus_if.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    drive(1'b1, 64'hABCD, 1'b0, 5'd7);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'd0);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 64'hABCD || bus_if.out_tag !== 5'd7 || count !== 3'd1) begin
      errors++; $display("[TB] FAIL reuse_after_reset got %b/%h/%0d/%0d want 1/abcd/7/1", bus_if.out_valid, bus_if.out_data, bus_if.out_tag, count);
    end
  endtask

  initial begin
    test_reset();
    test_ovf_push();
    test_fill_full();
    test_full_pop();
    test_back_to_back();
    test_sticky();
    test_ovf_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
